// File: rtl/all_module.sv
// Programmable 3-input Boolean function unit with input-coverage tracking.
// y is a truth-table lookup of {a,b,c}. y_q is a registered copy of y.
// seen records which of the 8 input combinations have occurred, and
// all_seen flags full coverage.
module all_module #(
    parameter logic [7:0] TRUTH_TABLE = 8'b1110_1000,
    parameter logic       RESET_Y     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       clear,
    output logic       y,
    output logic       y_q,
    output logic [7:0] seen,
    output logic       all_seen
);

    logic [2:0] idx;
    logic       y_q_d;
    logic       y_q_q;
    logic [7:0] seen_d;
    logic [7:0] seen_q;

    assign idx = {a, b, c};

    // Zero-latency lookup; independent of clk and rst.
    always_comb begin
        y = TRUTH_TABLE[idx];
    end

    // Next-state: clear has priority over the same-cycle sample, and seen bits are sticky.
    always_comb begin
        y_q_d  = y;
        seen_d = seen_q | (8'h01 << idx);
        if (clear) begin
            seen_d = 8'h00;
        end
    end

    // Registered result and coverage state, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q_q  <= RESET_Y;
            seen_q <= 8'h00;
        end else begin
            y_q_q  <= y_q_d;
            seen_q <= seen_d;
        end
    end

    assign y_q      = y_q_q;
    assign seen     = seen_q;
    assign all_seen = &seen_q;

endmodule

// File: tb/tb_all_module.sv
// Directed bench for all_module using the default majority truth table.
module tb_all_module;

    logic       clk;
    logic       rst;
    logic       a;
    logic       b;
    logic       c;
    logic       clear;
    logic       y;
    logic       y_q;
    logic [7:0] seen;
    logic       all_seen;

    int n_vec;
    int n_err;

    typedef struct {
        logic [2:0] idx;
        logic       clr;
        logic       exp_y;
        logic       exp_y_q;
        logic [7:0] exp_seen;
        logic       exp_all;
    } vec_t;

    vec_t vecs [13];

    all_module dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .c        (c),
        .clear    (clear),
        .y        (y),
        .y_q      (y_q),
        .seen     (seen),
        .all_seen (all_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_idx(input int i);
        logic [2:0] v;
        v = i[2:0];
        {a, b, c} = v;
    endtask

    initial begin
        logic [7:0] maj;
        n_vec = 0;
        n_err = 0;
        maj   = 8'b1110_1000;

        //          idx   clr  y     y_q   seen   all
        vecs[0]  = '{3'd0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0};
        vecs[1]  = '{3'd1, 1'b0, 1'b0, 1'b0, 8'h03, 1'b0};
        vecs[2]  = '{3'd2, 1'b0, 1'b0, 1'b0, 8'h07, 1'b0};
        vecs[3]  = '{3'd3, 1'b0, 1'b1, 1'b1, 8'h0F, 1'b0};
        vecs[4]  = '{3'd4, 1'b0, 1'b0, 1'b0, 8'h1F, 1'b0};
        vecs[5]  = '{3'd5, 1'b0, 1'b1, 1'b1, 8'h3F, 1'b0};
        vecs[6]  = '{3'd6, 1'b0, 1'b1, 1'b1, 8'h7F, 1'b0};
        vecs[7]  = '{3'd7, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1};
        vecs[8]  = '{3'd3, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1};
        vecs[9]  = '{3'd5, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0};
        vecs[10] = '{3'd5, 1'b0, 1'b1, 1'b1, 8'h20, 1'b0};
        vecs[11] = '{3'd5, 1'b0, 1'b1, 1'b1, 8'h20, 1'b0};
        vecs[12] = '{3'd0, 1'b0, 1'b0, 1'b0, 8'h21, 1'b0};

        rst   = 1'b1;
        clear = 1'b0;
        set_idx(0);

        // Combinational sweep while held in reset.
        for (int i = 0; i < 8; i++) begin
            set_idx(i);
            #5;
            chk($sformatf("comb_y[%0d]", i), {7'b0, y}, {7'b0, maj[i]});
        end
        chk("rst_y_q", {7'b0, y_q}, 8'h00);
        chk("rst_seen", seen, 8'h00);
        chk("rst_all", {7'b0, all_seen}, 8'h00);

        // Table-driven sweep, coverage, repeat and clear priority.
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 13; k++) begin
            set_idx(int'(vecs[k].idx));
            clear = vecs[k].clr;
            #1;
            chk($sformatf("v%0d_y", k), {7'b0, y}, {7'b0, vecs[k].exp_y});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_y_q", k), {7'b0, y_q}, {7'b0, vecs[k].exp_y_q});
            chk($sformatf("v%0d_seen", k), seen, vecs[k].exp_seen);
            chk($sformatf("v%0d_all", k), {7'b0, all_seen}, {7'b0, vecs[k].exp_all});
            @(negedge clk);
        end
        clear = 1'b0;

        // Repeats: idx 3 five times from reset.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        set_idx(3);
        repeat (5) @(posedge clk);
        #1;
        chk("rep_seen", seen, 8'h08);
        chk("rep_all", {7'b0, all_seen}, 8'h00);
        chk("rep_y_q", {7'b0, y_q}, 8'h01);

        // Async reset mid-sweep after idx 0..3.
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_idx(i);
            @(negedge clk);
        end
        chk("mid_seen_pre", seen, 8'h0F);
        chk("mid_y_q_pre", {7'b0, y_q}, 8'h01);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_seen_rst", seen, 8'h00);
        chk("mid_y_q_rst", {7'b0, y_q}, 8'h00);
        chk("mid_all_rst", {7'b0, all_seen}, 8'h00);
        set_idx(7);
        #1;
        chk("mid_y_track", {7'b0, y}, 8'h01);
        @(negedge clk);
        rst = 1'b0;
        set_idx(2);
        @(posedge clk);
        #1;
        chk("post_rst_seen", seen, 8'h04);
        chk("post_rst_y_q", {7'b0, y_q}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
